// File: rtl/axi_pkg.sv
// Shared AXI3 encodings and FSM state types for the SRAM slave.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [2:0] SIZE_WORD   = 3'b010;

  typedef enum logic {R_IDLE, R_BURST} rState_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wState_e;

endpackage

// File: rtl/axi_slave_addr_gen.sv
// Combinational next-beat address, word index and per-beat error check.
// WRAP bursts are only honoured when AXI_SLAVE_WRAP_EN is defined.
module axi_slave_addr_gen #(
  parameter int unsigned DEPTH     = 2048,
  parameter logic [31:0] BASE_ADDR = 32'h1fc0_0000
) (
  input  logic [31:0]              addr_i,
  input  logic [7:0]               len_i,
  input  logic [2:0]               size_i,
  input  logic [1:0]               burst_i,
  output logic [31:0]              nextAddr_o,
  output logic [$clog2(DEPTH)-1:0] wordIdx_o,
  output logic                     err_o
);
  import axi_pkg::*;

  localparam int unsigned IDXW = $clog2(DEPTH);
  localparam logic [31:0] SPAN = 32'(DEPTH) << 2;

  logic inRange;
  logic burstOk;

`ifdef AXI_SLAVE_WRAP_EN
  logic [31:0] wrapMask;
  logic        wrapLenOk;
  assign wrapMask  = {22'b0, len_i, 2'b11};
  assign wrapLenOk = (len_i == 8'd1) || (len_i == 8'd3) || (len_i == 8'd7) || (len_i == 8'd15);
`else
  logic unused_len;
  assign unused_len = ^len_i;
`endif

  // Base is aligned to the array span, so a masked compare is the range check.
  assign inRange   = (addr_i & ~(SPAN - 32'd1)) == BASE_ADDR;
  assign wordIdx_o = addr_i[IDXW+1:2];

  always_comb begin
    nextAddr_o = addr_i;
    burstOk    = 1'b0;
    case (burst_i)
      BURST_FIXED: burstOk = 1'b1;
      BURST_INCR: begin
        nextAddr_o = addr_i + 32'd4;
        burstOk    = 1'b1;
      end
`ifdef AXI_SLAVE_WRAP_EN
      BURST_WRAP: begin
        nextAddr_o = (addr_i & ~wrapMask) | ((addr_i + 32'd4) & wrapMask);
        burstOk    = wrapLenOk;
      end
`endif
      default: burstOk = 1'b0;
    endcase
    err_o = !inRange || (size_i != SIZE_WORD) || !burstOk;
  end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 slave backed by a word-addressed on-chip array; independent read and
// write FSMs. Define AXI_SLAVE_WRAP_EN to support WRAP bursts.
module axi_sram_slave #(
  parameter int unsigned DEPTH     = 2048,
  parameter logic [31:0] BASE_ADDR = 32'h1fc0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);
  import axi_pkg::*;

  localparam int unsigned IDXW = $clog2(DEPTH);

  logic [31:0] mem [DEPTH];

  rState_e     rState_q, rState_d;
  logic [3:0]  rId_q, rId_d;
  logic [31:0] rAddr_q, rAddr_d;
  logic [7:0]  rLen_q, rLen_d, rCnt_q, rCnt_d;
  logic [2:0]  rSize_q, rSize_d;
  logic [1:0]  rBurst_q, rBurst_d;

  wState_e     wState_q, wState_d;
  logic [3:0]  wId_q, wId_d;
  logic [31:0] wAddr_q, wAddr_d;
  logic [7:0]  wLen_q, wLen_d, wCnt_q, wCnt_d;
  logic [2:0]  wSize_q, wSize_d;
  logic [1:0]  wBurst_q, wBurst_d;
  logic        wErr_q, wErr_d;

  logic [31:0]     rNext, wNext;
  logic [IDXW-1:0] rIdx, wIdx;
  logic            rBeatErr, wBeatErr, memWrite;

  logic unused_sideband;
  assign unused_sideband = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid};

  axi_slave_addr_gen #(.DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) u_rdGen (
    .addr_i(rAddr_q), .len_i(rLen_q), .size_i(rSize_q), .burst_i(rBurst_q),
    .nextAddr_o(rNext), .wordIdx_o(rIdx), .err_o(rBeatErr)
  );

  axi_slave_addr_gen #(.DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) u_wrGen (
    .addr_i(wAddr_q), .len_i(wLen_q), .size_i(wSize_q), .burst_i(wBurst_q),
    .nextAddr_o(wNext), .wordIdx_o(wIdx), .err_o(wBeatErr)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rState_q <= R_IDLE;
      rId_q    <= '0;
      rAddr_q  <= '0;
      rLen_q   <= '0;
      rCnt_q   <= '0;
      rSize_q  <= '0;
      rBurst_q <= '0;
      wState_q <= W_IDLE;
      wId_q    <= '0;
      wAddr_q  <= '0;
      wLen_q   <= '0;
      wCnt_q   <= '0;
      wSize_q  <= '0;
      wBurst_q <= '0;
      wErr_q   <= 1'b0;
    end else begin
      rState_q <= rState_d;
      rId_q    <= rId_d;
      rAddr_q  <= rAddr_d;
      rLen_q   <= rLen_d;
      rCnt_q   <= rCnt_d;
      rSize_q  <= rSize_d;
      rBurst_q <= rBurst_d;
      wState_q <= wState_d;
      wId_q    <= wId_d;
      wAddr_q  <= wAddr_d;
      wLen_q   <= wLen_d;
      wCnt_q   <= wCnt_d;
      wSize_q  <= wSize_d;
      wBurst_q <= wBurst_d;
      wErr_q   <= wErr_d;
    end
  end

  // Read data comes straight from the array, so a same-edge write is seen only by later beats.
  always_comb begin
    rState_d = rState_q;
    rId_d    = rId_q;
    rAddr_d  = rAddr_q;
    rLen_d   = rLen_q;
    rCnt_d   = rCnt_q;
    rSize_d  = rSize_q;
    rBurst_d = rBurst_q;
    arready  = 1'b0;
    rvalid   = 1'b0;
    rlast    = 1'b0;
    rresp    = RESP_OKAY;
    rdata    = '0;
    rid      = rId_q;
    case (rState_q)
      R_IDLE: begin
        arready = 1'b1;
        if (arvalid) begin
          rId_d    = arid;
          rAddr_d  = araddr;
          rLen_d   = arlen;
          rSize_d  = arsize;
          rBurst_d = arburst;
          rCnt_d   = '0;
          rState_d = R_BURST;
        end
      end
      R_BURST: begin
        rvalid = 1'b1;
        rlast  = (rCnt_q == rLen_q);
        if (rBeatErr) rresp = RESP_SLVERR;
        else          rdata = mem[rIdx];
        if (rready) begin
          rAddr_d = rNext;
          rCnt_d  = rCnt_q + 8'd1;
          if (rlast) rState_d = R_IDLE;
        end
      end
      default: rState_d = R_IDLE;
    endcase
  end

  // The beat count, not wlast, ends a write burst; a wlast disagreement only poisons bresp.
  always_comb begin
    wState_d = wState_q;
    wId_d    = wId_q;
    wAddr_d  = wAddr_q;
    wLen_d   = wLen_q;
    wCnt_d   = wCnt_q;
    wSize_d  = wSize_q;
    wBurst_d = wBurst_q;
    wErr_d   = wErr_q;
    awready  = 1'b0;
    wready   = 1'b0;
    bvalid   = 1'b0;
    bresp    = RESP_OKAY;
    bid      = wId_q;
    case (wState_q)
      W_IDLE: begin
        awready = 1'b1;
        if (awvalid) begin
          wId_d    = awid;
          wAddr_d  = awaddr;
          wLen_d   = awlen;
          wSize_d  = awsize;
          wBurst_d = awburst;
          wCnt_d   = '0;
          wErr_d   = 1'b0;
          wState_d = W_DATA;
        end
      end
      W_DATA: begin
        wready = 1'b1;
        if (wvalid) begin
          wAddr_d = wNext;
          wCnt_d  = wCnt_q + 8'd1;
          wErr_d  = wErr_q | wBeatErr | (wlast != (wCnt_q == wLen_q));
          if (wCnt_q == wLen_q) wState_d = W_RESP;
        end
      end
      W_RESP: begin
        bvalid = 1'b1;
        bresp  = wErr_q ? RESP_SLVERR : RESP_OKAY;
        if (bready) wState_d = W_IDLE;
      end
      default: wState_d = W_IDLE;
    endcase
  end

  assign memWrite = wready && wvalid && !wBeatErr;

  always_ff @(posedge clk) begin
    if (memWrite) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[wIdx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed self-checking bench for axi_sram_slave (default or WRAP-enabled build).
module tb_axi_sram_slave;

  localparam int unsigned DEPTH = 2048;
  localparam logic [31:0] BASE  = 32'h1fc0_0000;
  localparam logic [1:0]  FIXED = 2'b00;
  localparam logic [1:0]  INCR  = 2'b01;
  localparam logic [1:0]  WRAP  = 2'b10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  arid = '0;
  logic [31:0] araddr = '0;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = 3'b010;
  logic [1:0]  arburst = 2'b01;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid;
  logic        rready = 1'b0;
  logic [3:0]  awid = '0;
  logic [31:0] awaddr = '0;
  logic [7:0]  awlen = '0;
  logic [2:0]  awsize = 3'b010;
  logic [1:0]  awburst = 2'b01;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;

  int checks = 0;
  int passes = 0;

  logic [31:0] wBuf [16];
  logic [31:0] rDataBuf [16];
  logic [1:0]  rRespBuf [16];
  logic        rLastBuf [16];
  logic [3:0]  rIdBuf [16];
  int          rCount, rFirstWait, stallBad, bWait;
  logic        arreadyAfter;
  logic [1:0]  bRespGot;
  logic [3:0]  bIdGot;

  axi_sram_slave #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(2'b00), .arcache(4'h0), .arprot(3'b000),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(2'b00), .awcache(4'h0), .awprot(3'b000),
    .awvalid(awvalid), .awready(awready),
    .wid(4'h0), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axiWrite(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic [3:0] id, input logic [3:0] strb, input int lastIdx);
    int guard;
    awaddr = addr; awlen = len; awburst = burst; awsize = 3'b010; awid = id; awvalid = 1'b1;
    guard = 0;
    while (!awready && guard < 20) begin tick(); guard++; end
    tick();
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wdata = wBuf[i]; wstrb = strb; wlast = (i == lastIdx); wvalid = 1'b1;
      guard = 0;
      while (!wready && guard < 20) begin tick(); guard++; end
      if (!wready) begin
        checks++;
        $display("[TB] FAIL w_timeout: wready=%b required 1", wready);
        break;
      end
      tick();
    end
    wvalid = 1'b0; wlast = 1'b0;
    bWait = 0;
    while (!bvalid && bWait < 20) begin tick(); bWait++; end
    if (!bvalid) begin
      checks++;
      $display("[TB] FAIL b_timeout: bvalid=%b required 1", bvalid);
    end
    bRespGot = bresp; bIdGot = bid;
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  task automatic axiRead(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                         input logic [2:0] size, input logic [3:0] id, input bit toggle);
    int cyc, guard;
    logic stalled, hl;
    logic [31:0] hd;
    logic [1:0] hr;
    araddr = addr; arlen = len; arburst = burst; arsize = size; arid = id; arvalid = 1'b1;
    guard = 0;
    while (!arready && guard < 20) begin tick(); guard++; end
    tick();
    arvalid = 1'b0;
    rCount = 0; rFirstWait = -1; stallBad = 0; stalled = 1'b0; cyc = 0;
    hd = '0; hl = 1'b0; hr = '0;
    while (rCount <= int'(len) && cyc < 100) begin
      rready = toggle ? cyc[0] : 1'b1;
      if (stalled && (!rvalid || rdata !== hd || rlast !== hl || rresp !== hr)) stallBad++;
      if (rvalid && rFirstWait < 0) rFirstWait = cyc;
      if (rvalid && rready) begin
        rDataBuf[rCount] = rdata; rRespBuf[rCount] = rresp;
        rLastBuf[rCount] = rlast; rIdBuf[rCount] = rid;
        rCount++;
        stalled = 1'b0;
      end else if (rvalid) begin
        stalled = 1'b1; hd = rdata; hl = rlast; hr = rresp;
      end
      tick();
      cyc++;
    end
    rready = 1'b0;
    arreadyAfter = arready;
    if (rCount <= int'(len)) begin
      checks++;
      $display("[TB] FAIL r_timeout: beats=%0d required %0d", rCount, int'(len) + 1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(); tick();
    checks++;
    if ({arready, awready, rvalid, rlast, rid, rdata, rresp, wready, bvalid, bid, bresp} !==
        {1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 2'b00, 1'b0, 1'b0, 4'h0, 2'b00})
      $display("[TB] FAIL reset_values: ar=%b aw=%b rv=%b rl=%b rid=%h rd=%h rr=%b wr=%b bv=%b bid=%h br=%b required ar/aw=1 others 0",
               arready, awready, rvalid, rlast, rid, rdata, rresp, wready, bvalid, bid, bresp);
    else passes++;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_incr();
    for (int i = 0; i < 8; i++) wBuf[i] = 32'h100 + i;
    axiWrite(BASE + 32'h20, 8'd7, INCR, 4'h9, 4'hf, 7);
    checks++;
    if ({bRespGot, bIdGot} !== {2'b00, 4'h9}) $display("[TB] FAIL incr_bresp: resp=%b bid=%h required 00/9", bRespGot, bIdGot);
    else passes++;
    checks++;
    if (bWait !== 0) $display("[TB] FAIL incr_b_latency: wait=%0d required 0", bWait);
    else passes++;
    axiRead(BASE + 32'h20, 8'd7, INCR, 3'b010, 4'h5, 1'b0);
    checks++;
    if (rFirstWait !== 0) $display("[TB] FAIL incr_r_latency: wait=%0d required 0", rFirstWait);
    else passes++;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({rDataBuf[i], rRespBuf[i], rLastBuf[i], rIdBuf[i]} !== {32'h100 + 32'(i), 2'b00, (i == 7), 4'h5})
        $display("[TB] FAIL incr_beat%0d: data=%h resp=%b last=%b id=%h required %h/00/%b/5",
                 i, rDataBuf[i], rRespBuf[i], rLastBuf[i], rIdBuf[i], 32'h100 + i, (i == 7));
      else passes++;
    end
    checks++;
    if (arreadyAfter !== 1'b1) $display("[TB] FAIL incr_arready_back: arready=%b required 1", arreadyAfter);
    else passes++;
  endtask

  task automatic test_backpressure();
    axiRead(BASE + 32'h20, 8'd3, INCR, 3'b010, 4'h3, 1'b1);
    checks++;
    if (stallBad !== 0) $display("[TB] FAIL bp_stable: unstable_cycles=%0d required 0", stallBad);
    else passes++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rDataBuf[i] !== 32'h100 + 32'(i)) $display("[TB] FAIL bp_beat%0d: data=%h required %h", i, rDataBuf[i], 32'h100 + i);
      else passes++;
    end
  endtask

  task automatic test_strobes();
    wBuf[0] = 32'h1122_3344;
    axiWrite(BASE + 32'h40, 8'd0, INCR, 4'h1, 4'hf, 0);
    wBuf[0] = 32'hAABB_CCDD;
    axiWrite(BASE + 32'h40, 8'd0, INCR, 4'h1, 4'b0101, 0);
    axiRead(BASE + 32'h40, 8'd0, INCR, 3'b010, 4'h1, 1'b0);
    checks++;
    if (rDataBuf[0] !== 32'h11BB_33DD) $display("[TB] FAIL strobe_merge: data=%h required 11bb33dd", rDataBuf[0]);
    else passes++;
  endtask

  task automatic test_fixed();
    for (int i = 0; i < 4; i++) wBuf[i] = 32'h400 + i;
    axiWrite(BASE + 32'hA0, 8'd3, FIXED, 4'h2, 4'hf, 3);
    axiRead(BASE + 32'hA0, 8'd2, FIXED, 3'b010, 4'h2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rDataBuf[i] !== 32'h403) $display("[TB] FAIL fixed_beat%0d: data=%h required 403", i, rDataBuf[i]);
      else passes++;
    end
    axiRead(BASE + 32'hA4, 8'd0, INCR, 3'b010, 4'h2, 1'b0);
    checks++;
    if (rDataBuf[0] === 32'h401) $display("[TB] FAIL fixed_no_advance: data=%h required not 401", rDataBuf[0]);
    else passes++;
  endtask

  task automatic test_errors();
    axiRead(BASE + DEPTH * 4, 8'd0, INCR, 3'b010, 4'h7, 1'b0);
    checks++;
    if ({rRespBuf[0], rDataBuf[0]} !== {2'b10, 32'h0}) $display("[TB] FAIL err_above: resp=%b data=%h required 10/0", rRespBuf[0], rDataBuf[0]);
    else passes++;
    axiRead(BASE - 32'd4, 8'd0, INCR, 3'b010, 4'h7, 1'b0);
    checks++;
    if (rRespBuf[0] !== 2'b10) $display("[TB] FAIL err_below: resp=%b required 10", rRespBuf[0]);
    else passes++;
    axiRead(BASE + 32'h20, 8'd0, INCR, 3'b001, 4'h7, 1'b0);
    checks++;
    if ({rRespBuf[0], rDataBuf[0]} !== {2'b10, 32'h0}) $display("[TB] FAIL err_size: resp=%b data=%h required 10/0", rRespBuf[0], rDataBuf[0]);
    else passes++;
    axiRead(BASE + 32'h20, 8'd0, 2'b11, 3'b010, 4'h7, 1'b0);
    checks++;
    if (rRespBuf[0] !== 2'b10) $display("[TB] FAIL err_burst11: resp=%b required 10", rRespBuf[0]);
    else passes++;
    for (int i = 0; i < 4; i++) wBuf[i] = 32'h300 + i;
    axiWrite(BASE + 32'h80, 8'd3, INCR, 4'h4, 4'hf, 1);
    checks++;
    if (bRespGot !== 2'b10) $display("[TB] FAIL err_early_wlast: bresp=%b required 10", bRespGot);
    else passes++;
    wBuf[0] = 32'hDEAD_BEEF;
    axiWrite(BASE + DEPTH * 4, 8'd0, INCR, 4'h4, 4'hf, 0);
    checks++;
    if (bRespGot !== 2'b10) $display("[TB] FAIL err_write_range: bresp=%b required 10", bRespGot);
    else passes++;
    axiWrite(BASE + 32'h90, 8'd0, INCR, 4'h4, 4'hf, 0);
    checks++;
    if (bRespGot !== 2'b00) $display("[TB] FAIL err_cleared: bresp=%b required 00", bRespGot);
    else passes++;
  endtask

  task automatic test_wrap();
    logic [31:0] expData [4];
    logic [1:0]  expResp;
    for (int i = 0; i < 4; i++) wBuf[i] = 32'h200 + i;
    axiWrite(BASE + 32'h10, 8'd3, INCR, 4'h6, 4'hf, 3);
    axiRead(BASE + 32'h18, 8'd3, WRAP, 3'b010, 4'h6, 1'b0);
`ifdef AXI_SLAVE_WRAP_EN
    expData[0] = 32'h202; expData[1] = 32'h203; expData[2] = 32'h200; expData[3] = 32'h201;
    expResp = 2'b00;
`else
    for (int i = 0; i < 4; i++) expData[i] = 32'h0;
    expResp = 2'b10;
`endif
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({rDataBuf[i], rRespBuf[i]} !== {expData[i], expResp})
        $display("[TB] FAIL wrap_beat%0d: data=%h resp=%b required %h/%b", i, rDataBuf[i], rRespBuf[i], expData[i], expResp);
      else passes++;
    end
  endtask

  task automatic test_reset_mid_burst();
    awaddr = BASE + 32'h60; awlen = 8'd3; awburst = INCR; awsize = 3'b010; awid = 4'h8; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    wdata = 32'hCAFE_0000; wstrb = 4'hf; wlast = 1'b0; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    araddr = BASE + 32'h20; arlen = 8'd7; arburst = INCR; arsize = 3'b010; arid = 4'hA; arvalid = 1'b1;
    tick();
    arvalid = 1'b0; rready = 1'b1;
    tick();
    rready = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({arready, awready, rvalid, bvalid, wready} !== 5'b11000)
      $display("[TB] FAIL mid_reset_idle: ar=%b aw=%b rv=%b bv=%b wr=%b required 1/1/0/0/0", arready, awready, rvalid, bvalid, wready);
    else passes++;
    axiRead(BASE + 32'h60, 8'd0, INCR, 3'b010, 4'h1, 1'b0);
    checks++;
    if (rDataBuf[0] !== 32'hCAFE_0000) $display("[TB] FAIL mid_reset_committed: data=%h required cafe0000", rDataBuf[0]);
    else passes++;
    axiRead(BASE + 32'h24, 8'd0, INCR, 3'b010, 4'h1, 1'b0);
    checks++;
    if (rDataBuf[0] !== 32'h101) $display("[TB] FAIL mid_reset_mem_intact: data=%h required 101", rDataBuf[0]);
    else passes++;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_incr();
    test_backpressure();
    test_strobes();
    test_fixed();
    test_errors();
    test_wrap();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
